// File: rtl/hsv_ctrl_pkg.sv
// Shared types and default geometry for the hist_v frame sequencer.
// Optional geometry checking is selected by HSV_FRAME_ERR_CHK_EN.
package hsv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int unsigned IMG_WIDTH_DEF  = 800;
  localparam int unsigned IMG_HEIGHT_DEF = 600;

endpackage

// File: rtl/frame_geom_chk.sv
// Per-frame geometry checker: counts pixels per line and lines per frame.
// Only instantiated when HSV_FRAME_ERR_CHK_EN is defined.
module frame_geom_chk #(
  parameter int unsigned IMG_WIDTH  = 800,
  parameter int unsigned IMG_HEIGHT = 600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clken_i,
  input  logic active_i,
  input  logic vs_lead_i,
  output logic frame_bad_o
);

  localparam int unsigned PW = $clog2(IMG_WIDTH + 1);
  localparam int unsigned LW = $clog2(IMG_HEIGHT + 2);

  logic          clken_q, clken_qq, line_end, line_bad_q;
  logic [PW-1:0] pix_cnt_q;
  logic [LW-1:0] line_cnt_q;

  assign line_end    = clken_qq && !clken_q;
  assign frame_bad_o = line_bad_q || (line_cnt_q != LW'(IMG_HEIGHT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clken_q    <= 1'b0;
      clken_qq   <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      line_bad_q <= 1'b0;
    end else begin
      clken_q  <= clken_i;
      clken_qq <= clken_q;
      if (vs_lead_i) begin
        pix_cnt_q  <= '0;
        line_cnt_q <= '0;
        line_bad_q <= 1'b0;
      end else if (active_i) begin
        if (line_end) begin
          if (pix_cnt_q != PW'(IMG_WIDTH)) line_bad_q <= 1'b1;
          if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + LW'(1);
          pix_cnt_q <= '0;
        end else if (clken_q && (pix_cnt_q != '1)) begin
          pix_cnt_q <= pix_cnt_q + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/hsv_frame_ctrl.sv
// Frame-boundary sequencer for hist_v: applies run/stop configs at vsync leading edges.
// Define HSV_FRAME_ERR_CHK_EN to include frame geometry checking (frame_err).
module hsv_frame_ctrl
  import hsv_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH      = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT     = IMG_HEIGHT_DEF,
  parameter int unsigned FRAME_CNT_W    = 16,
  parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_enable,
  input  logic [FRAME_CNT_W-1:0] cfg_nframes,
  input  logic                   pre_vs,
  input  logic                   pre_hs,
  input  logic                   pre_clken,
  output logic                   process_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frames_left
);

  state_e                 state_q;
  logic                   vs_q, vs_qq, vs_lead, cfg_xfer, frame_bad;
  logic                   pend_valid_q, pend_en_q;
  logic [FRAME_CNT_W-1:0] pend_n_q, frames_left_q, frames_dec_d;
  logic                   process_en_q, busy_q, frame_done_q, frame_err_q;

  assign vs_lead      = (vs_q == VS_ACTIVE_HIGH) && (vs_qq != VS_ACTIVE_HIGH);
  assign cfg_xfer     = cfg_valid && !pend_valid_q;
  assign frames_dec_d = (frames_left_q != '0) ? frames_left_q - FRAME_CNT_W'(1) : '0;

  assign cfg_ready   = !pend_valid_q;
  assign process_en  = process_en_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frames_left = frames_left_q;

`ifdef HSV_FRAME_ERR_CHK_EN
  frame_geom_chk #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_geom (
    .clk        (clk),
    .rst_n      (rst_n),
    .clken_i    (pre_clken),
    .active_i   (state_q == ACTIVE),
    .vs_lead_i  (vs_lead),
    .frame_bad_o(frame_bad)
  );
  logic unused_hs;
  assign unused_hs = pre_hs;
`else
  assign frame_bad = 1'b0;
  logic unused_in;
  assign unused_in = ^{pre_hs, pre_clken, IMG_WIDTH[0], IMG_HEIGHT[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      vs_q          <= ~VS_ACTIVE_HIGH;
      vs_qq         <= ~VS_ACTIVE_HIGH;
      pend_valid_q  <= 1'b0;
      pend_en_q     <= 1'b0;
      pend_n_q      <= '0;
      frames_left_q <= '0;
      process_en_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      vs_q         <= pre_vs;
      vs_qq        <= vs_q;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      // Slot fill and consume never coincide: consume needs a full slot, fill an empty one.
      if (cfg_xfer) begin
        pend_valid_q <= 1'b1;
        pend_en_q    <= cfg_enable;
        pend_n_q     <= cfg_nframes;
      end
      case (state_q)
        IDLE: begin
          if (cfg_xfer && cfg_enable) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
          end
          if (vs_lead && pend_valid_q) pend_valid_q <= 1'b0;
        end
        ARMED: begin
          if (vs_lead && pend_valid_q && pend_en_q) begin
            state_q       <= ACTIVE;
            frames_left_q <= pend_n_q;
            process_en_q  <= 1'b1;
            pend_valid_q  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vs_lead) begin
            frame_done_q <= 1'b1;
            frame_err_q  <= frame_bad;
            // A pending run config beats both count expiry and the decrement.
            if (pend_valid_q) begin
              pend_valid_q <= 1'b0;
              if (pend_en_q) begin
                frames_left_q <= pend_n_q;
              end else begin
                frames_left_q <= frames_dec_d;
                state_q       <= IDLE;
                process_en_q  <= 1'b0;
                busy_q        <= 1'b0;
              end
            end else if ((frames_left_q != '0) && (frames_dec_d == '0)) begin
              frames_left_q <= '0;
              state_q       <= IDLE;
              process_en_q  <= 1'b0;
              busy_q        <= 1'b0;
            end else begin
              frames_left_q <= frames_dec_d;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          process_en_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_frame_ctrl.sv
// Self-checking bench for hsv_frame_ctrl against a frame-level reference model.
module tb_hsv_frame_ctrl;

  localparam int W   = 12;
  localparam int H   = 5;
  localparam int FCW = 8;
  localparam bit VS_AH = 1'b1;
`ifdef HSV_FRAME_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_valid, cfg_ready, cfg_enable;
  logic [FCW-1:0] cfg_nframes;
  logic           pre_vs, pre_hs, pre_clken;
  logic           process_en, busy, frame_done, frame_err;
  logic [FCW-1:0] frames_left;

  always #5 clk = ~clk;

  hsv_frame_ctrl #(
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H),
    .FRAME_CNT_W   (FCW),
    .VS_ACTIVE_HIGH(VS_AH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_enable (cfg_enable),
    .cfg_nframes(cfg_nframes),
    .pre_vs     (pre_vs),
    .pre_hs     (pre_hs),
    .pre_clken  (pre_clken),
    .process_en (process_en),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frames_left(frames_left)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the sequencer.
  bit          m_act, m_arm, m_cont, m_pend, m_pend_run;
  int unsigned m_todo, m_pend_n;
  bit          cur_bad;
  int unsigned exp_done_cnt = 0, exp_err_cnt = 0;
  int unsigned done_seen = 0, err_seen = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  function automatic int unsigned exp_left();
    return m_cont ? 0 : m_todo;
  endfunction

  task automatic model_reset();
    m_act = 0; m_arm = 0; m_cont = 0; m_pend = 0; m_pend_run = 0;
    m_todo = 0; m_pend_n = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int len);
    pre_hs = 1'b1;
    pre_clken = 1'b1;
    repeat (len) tick();
    pre_clken = 1'b0;
    pre_hs = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_cfg(input bit en, input int unsigned n);
    int waited = 0;
    cfg_valid = 1'b1;
    cfg_enable = en;
    cfg_nframes = FCW'(n);
    while (cfg_ready !== 1'b1 && waited < 16) begin
      tick();
      waited++;
    end
    check_eq("cfg_accept", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    m_pend = 1; m_pend_run = en; m_pend_n = n;
    if (!m_act && !m_arm && en) m_arm = 1;
    check_eq("cfg_ready_full", cfg_ready, 0);
    check_eq("busy_after_cfg", busy, 32'(m_act || m_arm));
  endtask

  task automatic frame(input int nlines, input int bad_idx, input int bad_len,
                       input int cfg_line, input bit cfg_en, input int unsigned cfg_n);
    cur_bad = (nlines != H) || (bad_idx >= 0 && bad_idx < nlines && bad_len != W);
    for (int i = 0; i < nlines; i++) begin
      if (i == cfg_line) send_cfg(cfg_en, cfg_n);
      send_line((i == bad_idx) ? bad_len : W);
    end
  endtask

  task automatic good_frame();
    frame(H, -1, W, -1, 1'b0, 0);
  endtask

  task automatic boundary(input string tag);
    bit ed, ee;
    pre_vs = VS_AH;
    tick();
    tick();
    ed = 0; ee = 0;
    if (m_act) begin
      ed = 1;
      ee = ERR_EN && cur_bad;
      if (!m_cont) m_todo--;
      if (m_pend && m_pend_run) begin
        m_cont = (m_pend_n == 0); m_todo = m_pend_n;
      end else if (m_pend) begin
        m_act = 0;
      end else if (!m_cont && m_todo == 0) begin
        m_act = 0;
      end
      m_pend = 0;
    end else if (m_pend && m_pend_run) begin
      m_arm = 0; m_act = 1; m_pend = 0;
      m_cont = (m_pend_n == 0); m_todo = m_pend_n;
    end else if (m_pend) begin
      m_pend = 0;
    end
    exp_done_cnt += ed;
    exp_err_cnt += ee;
    check_eq({tag, ".process_en"}, process_en, 32'(m_act));
    check_eq({tag, ".busy"}, busy, 32'(m_act || m_arm));
    check_eq({tag, ".frame_done"}, frame_done, 32'(ed));
    check_eq({tag, ".frame_err"}, frame_err, 32'(ee));
    check_eq({tag, ".frames_left"}, frames_left, exp_left());
    check_eq({tag, ".cfg_ready"}, cfg_ready, 32'(!m_pend));
    tick();
    check_eq({tag, ".done_pulse"}, frame_done, 0);
    pre_vs = ~VS_AH;
    repeat (2) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    cfg_valid = 1'b0; cfg_enable = 1'b0; cfg_nframes = '0;
    pre_vs = ~VS_AH; pre_hs = 1'b0; pre_clken = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #2;
    check_eq("rst.process_en", process_en, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.frame_done", frame_done, 0);
    check_eq("rst.frame_err", frame_err, 0);
    check_eq("rst.frames_left", frames_left, 0);
    check_eq("rst.cfg_ready", cfg_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Finite run of two frames.
    send_cfg(1, 2);
    boundary("t1.enter");
    good_frame(); boundary("t1.f1");
    good_frame(); boundary("t1.f2");
    good_frame(); boundary("t1.idle");

    // Continuous run, stopped mid-frame.
    send_cfg(1, 0);
    boundary("t2.enter");
    good_frame(); boundary("t2.f1");
    good_frame(); boundary("t2.f2");
    frame(H, -1, W, 2, 1'b0, 0); boundary("t2.stop");

    // Geometry errors.
    send_cfg(1, 0);
    boundary("t3.enter");
    frame(H, 2, W - 1, -1, 1'b0, 0); boundary("t3.short_line");
    good_frame(); boundary("t3.good");
    frame(H - 1, -1, W, -1, 1'b0, 0); boundary("t4.few_lines");
    frame(H + 1, -1, W, -1, 1'b0, 0); boundary("t4.many_lines");
    frame(H, 4, W + 1, 1, 1'b0, 0); boundary("t4.long_stop");

    // Reload beats expiry; a full slot refuses further configs.
    send_cfg(1, 1);
    boundary("t5.enter");
    frame(H, -1, W, 1, 1'b1, 1);
    cfg_valid = 1'b1; cfg_enable = 1'b0; cfg_nframes = 8'd7;
    repeat (4) begin
      tick();
      check_eq("t5.hold_ready", cfg_ready, 0);
    end
    cfg_valid = 1'b0;
    boundary("t5.reload");
    good_frame(); boundary("t5.expire");

    // Asynchronous reset mid-frame.
    send_cfg(1, 3);
    boundary("t6.enter");
    send_line(W); send_line(W);
    pre_clken = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6.rst_process_en", process_en, 0);
    check_eq("t6.rst_busy", busy, 0);
    check_eq("t6.rst_cfg_ready", cfg_ready, 1);
    check_eq("t6.rst_frames_left", frames_left, 0);
    pre_clken = 1'b0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_cfg(1, 2);
    repeat (10) tick();
    check_eq("t6.armed_wait", process_en, 0);
    boundary("t6.enter2");
    good_frame(); boundary("t6.f1");

    // Randomised frames and configs.
    for (int it = 0; it < 40; it++) begin
      int r, nl, bi, bl, cl;
      bit ce;
      int unsigned cn;
      r = $urandom_range(0, 9);
      nl = H; bi = -1; bl = W; cl = -1; ce = 0; cn = 0;
      if (r == 0) nl = H - 1;
      if (r == 1) nl = H + 1;
      if (r == 2) begin
        bi = $urandom_range(0, H - 1);
        bl = ($urandom_range(0, 1) == 1) ? W - 1 : W + 2;
      end
      if (!m_pend && $urandom_range(0, 2) == 0) begin
        cl = $urandom_range(0, nl - 1);
        ce = ($urandom_range(0, 3) != 0);
        cn = $urandom_range(0, 3);
      end
      frame(nl, bi, bl, cl, ce, cn);
      boundary("rnd");
    end

    check_eq("total_done", done_seen, exp_done_cnt);
    check_eq("total_err", err_seen, exp_err_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
